// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and arbitration helper for mem_req_arbiter
// Contents: FSM state encoding, master index constants, winner-pick function.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Winner for the next grant. With both masters requesting, fixed
    // priority always favours m0; round-robin favours whoever was not
    // served last. Only meaningful when at least one request is set.
    function automatic logic pick(
        input logic req0,
        input logic req1,
        input logic last,
        input logic prio
    );
        logic win;
        if (req0 && req1) begin
            win = prio ? M0 : ~last;
        end else if (req1) begin
            win = M1;
        end else begin
            win = M0;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - two-master arbiter in front of the byte-bus sequencer port
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   mN_raddr/mN_rreq -> mN_rdata/mN_rdone    master N read request and response
//   mN_waddr/mN_wmask/mN_wdata -> mN_wdone   master N write request and response
//   s_raddr/s_rreq/s_waddr/s_wmask/s_wdata   request to the sequencer (granted master)
//   s_rdata/s_rdone/s_wdone           response from the sequencer
//   gnt                               one-hot current grant {m1,m0}, 00 when idle
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RV   = 16,
    parameter int PA   = 18,
    parameter int PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [PA-1:RV/16] m0_raddr,
    input  logic [RV/8-1:0]   m0_rreq,
    output logic [RV-1:0]     m0_rdata,
    output logic              m0_rdone,
    input  logic [PA-1:RV/16] m0_waddr,
    input  logic [RV/8-1:0]   m0_wmask,
    input  logic [RV-1:0]     m0_wdata,
    output logic              m0_wdone,

    input  logic [PA-1:RV/16] m1_raddr,
    input  logic [RV/8-1:0]   m1_rreq,
    output logic [RV-1:0]     m1_rdata,
    output logic              m1_rdone,
    input  logic [PA-1:RV/16] m1_waddr,
    input  logic [RV/8-1:0]   m1_wmask,
    input  logic [RV-1:0]     m1_wdata,
    output logic              m1_wdone,

    output logic [PA-1:RV/16] s_raddr,
    output logic [RV/8-1:0]   s_rreq,
    output logic [PA-1:RV/16] s_waddr,
    output logic [RV/8-1:0]   s_wmask,
    output logic [RV-1:0]     s_wdata,
    input  logic [RV-1:0]     s_rdata,
    input  logic              s_rdone,
    input  logic              s_wdone,

    output logic [1:0]        gnt
);

    arb_state_t state, state_d;
    logic       last, last_d;
    logic       req0, req1;
    logic       seq_done;

    assign req0     = (|m0_rreq) || (|m0_wmask);
    assign req1     = (|m1_rreq) || (|m1_wmask);
    assign seq_done = s_rdone || s_wdone;

    // Read data is registered inside the sequencer, so both masters can
    // simply watch it; only the done pulse says whose data it is.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            last  <= M1;
        end else begin
            state <= state_d;
            last  <= last_d;
        end
    end

    // A grant lasts until the sequencer's first done of either kind; a
    // master with both a read and a write pending re-arbitrates for the
    // second one. GAP always follows so the sequencer sees requests low
    // on its post-done cycle and again while we re-arbitrate in IDLE.
    always_comb begin
        state_d = state;
        last_d  = last;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = (pick(req0, req1, last, PRIO != 0) == M1) ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0: begin
                if (seq_done) begin
                    state_d = ST_GAP;
                    last_d  = M0;
                end
            end
            ST_GNT1: begin
                if (seq_done) begin
                    state_d = ST_GAP;
                    last_d  = M1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request mux and done routing come straight from the registered
    // state: the granted master's live request passes through, and done
    // pulses outside a grant (IDLE/GAP) are swallowed.
    always_comb begin
        gnt      = 2'b00;
        s_raddr  = '0;
        s_rreq   = '0;
        s_waddr  = '0;
        s_wmask  = '0;
        s_wdata  = '0;
        m0_rdone = 1'b0;
        m0_wdone = 1'b0;
        m1_rdone = 1'b0;
        m1_wdone = 1'b0;
        case (state)
            ST_GNT0: begin
                gnt      = 2'b01;
                s_raddr  = m0_raddr;
                s_rreq   = m0_rreq;
                s_waddr  = m0_waddr;
                s_wmask  = m0_wmask;
                s_wdata  = m0_wdata;
                m0_rdone = s_rdone;
                m0_wdone = s_wdone;
            end
            ST_GNT1: begin
                gnt      = 2'b10;
                s_raddr  = m1_raddr;
                s_rreq   = m1_rreq;
                s_waddr  = m1_waddr;
                s_wmask  = m1_wmask;
                s_wdata  = m1_wdata;
                m1_rdone = s_rdone;
                m1_wdone = s_wdone;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter (round-robin and fixed-priority instances)
module tb_mem_req_arbiter;

    localparam int RV = 16;
    localparam int PA = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [PA-1:RV/16] m0_raddr, m1_raddr, m0_waddr, m1_waddr;
    logic [RV/8-1:0]   m0_rreq, m1_rreq, m0_wmask, m1_wmask;
    logic [RV-1:0]     m0_wdata, m1_wdata, s_rdata;
    logic              s_rdone, s_wdone;

    logic [RV-1:0]     a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata;
    logic              a_m0_rdone, a_m0_wdone, a_m1_rdone, a_m1_wdone;
    logic              b_m0_rdone, b_m0_wdone, b_m1_rdone, b_m1_wdone;
    logic [PA-1:RV/16] a_s_raddr, a_s_waddr, b_s_raddr, b_s_waddr;
    logic [RV/8-1:0]   a_s_rreq, a_s_wmask, b_s_rreq, b_s_wmask;
    logic [RV-1:0]     a_s_wdata, b_s_wdata;
    logic [1:0]        a_gnt, b_gnt;

    mem_req_arbiter #(.RV(RV), .PA(PA), .PRIO(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_raddr(m0_raddr), .m0_rreq(m0_rreq), .m0_rdata(a_m0_rdata), .m0_rdone(a_m0_rdone),
        .m0_waddr(m0_waddr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata), .m0_wdone(a_m0_wdone),
        .m1_raddr(m1_raddr), .m1_rreq(m1_rreq), .m1_rdata(a_m1_rdata), .m1_rdone(a_m1_rdone),
        .m1_waddr(m1_waddr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata), .m1_wdone(a_m1_wdone),
        .s_raddr(a_s_raddr), .s_rreq(a_s_rreq), .s_waddr(a_s_waddr), .s_wmask(a_s_wmask),
        .s_wdata(a_s_wdata), .s_rdata(s_rdata), .s_rdone(s_rdone), .s_wdone(s_wdone),
        .gnt(a_gnt)
    );

    mem_req_arbiter #(.RV(RV), .PA(PA), .PRIO(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_raddr(m0_raddr), .m0_rreq(m0_rreq), .m0_rdata(b_m0_rdata), .m0_rdone(b_m0_rdone),
        .m0_waddr(m0_waddr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata), .m0_wdone(b_m0_wdone),
        .m1_raddr(m1_raddr), .m1_rreq(m1_rreq), .m1_rdata(b_m1_rdata), .m1_rdone(b_m1_rdone),
        .m1_waddr(m1_waddr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata), .m1_wdone(b_m1_wdone),
        .s_raddr(b_s_raddr), .s_rreq(b_s_rreq), .s_waddr(b_s_waddr), .s_wmask(b_s_wmask),
        .s_wdata(b_s_wdata), .s_rdata(s_rdata), .s_rdone(s_rdone), .s_wdone(s_wdone),
        .gnt(b_gnt)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic [1:0]  rreq;
        logic [16:0] raddr;
        logic [1:0]  wmask;
        logic [16:0] waddr;
        logic [15:0] wdata;
    } gexp_t;

    typedef struct packed {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] rdata;
    } dexp_t;

    gexp_t qa[$];
    gexp_t qb[$];
    dexp_t qd[$];
    gexp_t ga, gb, ea, eb;
    dexp_t ed;
    logic [3:0] da, db;
    logic [1:0] pa, pb;

    assign ga = {a_gnt, a_s_rreq, a_s_raddr, a_s_wmask, a_s_waddr, a_s_wdata};
    assign gb = {b_gnt, b_s_rreq, b_s_raddr, b_s_wmask, b_s_waddr, b_s_wdata};
    assign da = {a_m0_rdone, a_m0_wdone, a_m1_rdone, a_m1_wdone};
    assign db = {b_m0_rdone, b_m0_wdone, b_m1_rdone, b_m1_wdone};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected no event", name, act);
    endtask

    // Monitor: a new non-zero grant or any done pulse is an output event.
    initial begin
        pa = 2'b00;
        pb = 2'b00;
        forever begin
            @(negedge clk);
            if (!$isunknown(a_gnt) && a_gnt != pa && a_gnt != 2'b00) begin
                if (qa.size() == 0) unexpected("grant_a", 64'(ga));
                else begin
                    ea = qa.pop_front();
                    chk("grant_a", 64'(ga), 64'(ea));
                end
            end
            if (!$isunknown(b_gnt) && b_gnt != pb && b_gnt != 2'b00) begin
                if (qb.size() == 0) unexpected("grant_b", 64'(gb));
                else begin
                    eb = qb.pop_front();
                    chk("grant_b", 64'(gb), 64'(eb));
                end
            end
            if ((|da) || (|db)) begin
                if (qd.size() == 0) unexpected("done", 64'({da, db}));
                else begin
                    ed = qd.pop_front();
                    chk("done", 64'({da, db, a_m0_rdata, a_m1_rdata}), 64'({ed.a, ed.b, ed.rdata, ed.rdata}));
                    chk("done_b_rdata", 64'({b_m0_rdata, b_m1_rdata}), 64'({ed.rdata, ed.rdata}));
                end
            end
            pa = a_gnt;
            pb = b_gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        while (a_gnt == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        if (a_gnt == 2'b00) begin
            checks++;
            errors++;
            $display("FAIL %s: gnt=00 after 20 cycles, expected a grant", name);
        end
    endtask

    task automatic pulse(input logic r, input logic w, input logic [15:0] d);
        s_rdata = d;
        s_rdone = r;
        s_wdone = w;
        tick();
        s_rdone = 1'b0;
        s_wdone = 1'b0;
    endtask

    // Called on the cycle after a done edge: expect GAP, then IDLE, both quiet.
    task automatic gap_check(input string name);
        chk({name, "_gap_a"}, 64'(ga), 64'd0);
        chk({name, "_gap_b"}, 64'(gb), 64'd0);
        tick();
        chk({name, "_idle_a"}, 64'(ga), 64'd0);
        chk({name, "_idle_b"}, 64'(gb), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    gexp_t g0, g1;

    initial begin
        rst_n    = 1'b0;
        m0_raddr = 17'h1234; m0_rreq = 2'b11; m0_waddr = '0; m0_wmask = '0; m0_wdata = '0;
        m1_raddr = '0;       m1_rreq = '0;    m1_waddr = '0; m1_wmask = '0; m1_wdata = '0;
        s_rdata  = '0; s_rdone = 1'b0; s_wdone = 1'b0;

        // Reset held two cycles with m0 requesting
        tick();
        tick();
        chk("reset_a", 64'(ga), 64'd0);
        chk("reset_b", 64'(gb), 64'd0);
        chk("reset_done", 64'({da, db}), 64'd0);
        qa.push_back(gexp_t'{2'b01, 2'b11, 17'h1234, 2'b00, 17'h0, 16'h0});
        qb.push_back(gexp_t'{2'b01, 2'b11, 17'h1234, 2'b00, 17'h0, 16'h0});
        rst_n = 1'b1;
        chk("release_idle", 64'(a_gnt), 64'd0);
        tick();
        chk("first_gnt", 64'(a_gnt), 64'd1);

        // Single read by m0
        repeat (5) tick();
        qd.push_back(dexp_t'{4'b1000, 4'b1000, 16'hBEEF});
        pulse(1'b1, 1'b0, 16'hBEEF);
        m0_rreq  = 2'b00;
        m0_raddr = '0;
        gap_check("read");

        // Spurious done while idle
        s_rdata = 16'h1111;
        s_rdone = 1'b1;
        #1;
        chk("spurious_fwd", 64'({da, db}), 64'd0);
        tick();
        s_rdone = 1'b0;
        chk("spurious_idle", 64'(ga), 64'd0);

        // m1 read+write, both dones in one cycle
        m1_rreq = 2'b01; m1_raddr = 17'h0456; m1_wmask = 2'b10; m1_waddr = 17'h0789; m1_wdata = 16'h5A5A;
        qa.push_back(gexp_t'{2'b10, 2'b01, 17'h0456, 2'b10, 17'h0789, 16'h5A5A});
        qb.push_back(gexp_t'{2'b10, 2'b01, 17'h0456, 2'b10, 17'h0789, 16'h5A5A});
        wait_gnt("simul");
        repeat (2) tick();
        qd.push_back(dexp_t'{4'b0011, 4'b0011, 16'hC0DE});
        pulse(1'b1, 1'b1, 16'hC0DE);
        m1_rreq = '0; m1_wmask = '0; m1_raddr = '0;
        gap_check("simul");

        // Contention: both write continuously
        m0_waddr = 17'h00A0; m0_wdata = 16'h1111; m0_wmask = 2'b11;
        m1_waddr = 17'h00B1; m1_wdata = 16'h2222; m1_wmask = 2'b11;
        g0 = gexp_t'{2'b01, 2'b00, 17'h0, 2'b11, 17'h00A0, 16'h1111};
        g1 = gexp_t'{2'b10, 2'b00, 17'h0, 2'b11, 17'h00B1, 16'h2222};
        for (int i = 0; i < 4; i++) begin
            qa.push_back((i % 2 == 1) ? g1 : g0);
            qb.push_back(g0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_gnt($sformatf("cont%0d", i));
            repeat (2) tick();
            qd.push_back(dexp_t'{((i % 2 == 1) ? 4'b0001 : 4'b0100), 4'b0100, 16'h0100 + 16'(i)});
            pulse(1'b0, 1'b1, 16'h0100 + 16'(i));
            gap_check($sformatf("cont%0d", i));
        end

        // m0 drops: fixed-priority instance now serves m1
        m0_wmask = '0;
        qa.push_back(g1);
        qb.push_back(g1);
        wait_gnt("m1_alone");
        repeat (2) tick();
        qd.push_back(dexp_t'{4'b0001, 4'b0001, 16'h0200});
        pulse(1'b0, 1'b1, 16'h0200);
        m1_wmask = '0;
        gap_check("m1_alone");

        // m0 alone, leaves last=m0 in both instances
        m0_wmask = 2'b01;
        qa.push_back(gexp_t'{2'b01, 2'b00, 17'h0, 2'b01, 17'h00A0, 16'h1111});
        qb.push_back(gexp_t'{2'b01, 2'b00, 17'h0, 2'b01, 17'h00A0, 16'h1111});
        wait_gnt("m0_alone");
        repeat (2) tick();
        qd.push_back(dexp_t'{4'b0100, 4'b0100, 16'h0300});
        pulse(1'b0, 1'b1, 16'h0300);
        m0_wmask = '0;
        gap_check("m0_alone");

        // Reset in the middle of an m1 grant, done arrives after release
        m1_wmask = 2'b01;
        qa.push_back(gexp_t'{2'b10, 2'b00, 17'h0, 2'b01, 17'h00B1, 16'h2222});
        qb.push_back(gexp_t'{2'b10, 2'b00, 17'h0, 2'b01, 17'h00B1, 16'h2222});
        wait_gnt("rst_mid");
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_mid_a", 64'(ga), 64'd0);
        chk("rst_mid_b", 64'(gb), 64'd0);
        m1_wmask = '0;
        rst_n    = 1'b1;
        s_wdone  = 1'b1;
        #1;
        chk("rst_drop_done", 64'({da, db}), 64'd0);
        tick();
        s_wdone = 1'b0;
        chk("rst_stay_idle", 64'(a_gnt), 64'd0);

        // Reset restored last=m1, so round-robin picks m0 first
        m0_wmask = 2'b01;
        m1_wmask = 2'b01;
        qa.push_back(gexp_t'{2'b01, 2'b00, 17'h0, 2'b01, 17'h00A0, 16'h1111});
        qb.push_back(gexp_t'{2'b01, 2'b00, 17'h0, 2'b01, 17'h00A0, 16'h1111});
        wait_gnt("post_rst");
        repeat (2) tick();
        qd.push_back(dexp_t'{4'b0100, 4'b0100, 16'h0400});
        pulse(1'b0, 1'b1, 16'h0400);
        m0_wmask = '0;
        m1_wmask = '0;
        gap_check("post_rst");

        repeat (3) tick();
        chk("qa_empty", 64'(qa.size()), 64'd0);
        chk("qb_empty", 64'(qb.size()), 64'd0);
        chk("qd_empty", 64'(qd.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single external byte-bus sequencer port (read: raddr/rreq/rdata/rdone; write: waddr/wmask/wdata/wdone) between two masters.
- m0 is the CPU; m1 is a secondary master (debug loader / DMA).
- Sits between the masters and the bus sequencer. Grants one master per transaction and holds the grant until the sequencer pulses done.
- Forces a one-cycle idle gap so the sequencer never resamples a stale request.

Parameters:
- RV, 16, data width; RV/8 write-mask bits.
- PA, 18, physical address width; addresses are [PA-1:RV/16].
- PRIO, 0, 0 = round-robin between m0/m1; 1 = fixed priority, m0 wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- m0_raddr, m1_raddr  in  PA-RV/16  master read address
- m0_rreq, m1_rreq  in  2  read request, byte-lane select, level
- m0_rdata, m1_rdata  out  RV  read data, both driven from s_rdata
- m0_rdone, m1_rdone  out  1  read done pulse
- m0_waddr, m1_waddr  in  PA-RV/16  write address
- m0_wmask, m1_wmask  in  RV/8  write byte mask, level
- m0_wdata, m1_wdata  in  RV  write data
- m0_wdone, m1_wdone  out  1  write done pulse
- s_raddr, s_rreq, s_waddr, s_wmask, s_wdata  out  as above  to sequencer
- s_rdata  in  RV  from sequencer
- s_rdone, s_wdone  in  1  from sequencer
- gnt  out  2  one-hot current grant {m1,m0}; 00 when idle

Behaviour:
- Per-master request: reqN = |mN_rreq | |mN_wmask.
- State machine, registered: IDLE, GNT0, GNT1, GAP.
- Reset (rst_n low at a clk edge):
  - state=IDLE, rr pointer last=1 (so m0 wins first), gnt=00.
  - All s_* request outputs 0; all done outputs 0.
  - Reset mid-transaction abandons the grant; done pulses arriving afterwards are dropped.
- IDLE:
  - If only one reqN is set, go to GNTN.
  - If both are set: PRIO=1 picks m0. PRIO=0 picks the master not equal to last.
  - If neither is set, stay in IDLE.
  - Requests are sampled at edge N; the s_* request appears combinationally from the registered grant at cycle N+1 (one-cycle arbitration latency).
- GNTN:
  - s_raddr/s_rreq/s_waddr/s_wmask/s_wdata = mN_* live (pass-through). The master must hold them until done.
  - Non-granted master sees done=0.
  - mN_rdone = s_rdone and mN_wdone = s_wdone, combinational same-cycle pass-through.
  - On s_rdone|s_wdone (either or both in the same cycle), set last=N and go to GAP.
  - A master dropping its request mid-grant is illegal. The grant is held until done regardless.
- GAP:
  - All s_* request outputs forced 0, gnt=00, then go to IDLE.
  - Guarantees at least 2 cycles of s_rreq=0/s_wmask=0 between transactions, covering the sequencer's post-done cycle.
- IDLE, GAP: s_rreq/s_wmask = 0; s_raddr/s_waddr/s_wdata = 0.
- Done pulses on s_rdone/s_wdone while in IDLE/GAP are spurious: ignored and not forwarded.
- m0_rdata = m1_rdata = s_rdata unconditionally. The sequencer holds it registered, so it is valid on the done cycle and until the next read.
- Read and write requested together by one master: both are forwarded and the sequencer orders them (write first). The grant is released on the first done; the master re-arbitrates for the remainder.
- Throughput: back-to-back same-master transactions cost done + GAP + IDLE = 2 extra cycles over the sequencer latency.
- Round-robin starvation bound: with both masters requesting continuously, grants strictly alternate.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding localparams (IDLE, GNT0, GNT1, GAP);
  - master index constants M0/M1;
  - pick function (req0, req1, last, prio) -> winner.
- No sub-module; the mux and FSM are a single flat block of roughly 150 lines.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with m0_rreq=11 -> all s_* request outputs 0 and gnt=00. First grant after release is m0 (gnt=01 at cycle 2 after rst_n rises).
- Single read: m0_rreq=11, m0_raddr=0x1234; sequencer model returns s_rdata=0xBEEF, s_rdone pulse at cycle 8 -> m0_rdone pulse in the same cycle, m0_rdata=0xBEEF, m1_rdone=0, then GAP with s_rreq=00 for at least 2 cycles.
- Contention, PRIO=0: m0 and m1 both hold wmask=11 continuously -> grant order m0, m1, m0, m1. Each wdone is routed only to the granted master; s_waddr switches only after GAP.
- Contention, PRIO=1: same stimulus -> m0 granted every time and m1 never granted while m0 requests; m1 is granted once m0 drops.
- Spurious and simultaneous done: s_rdone pulse in IDLE -> no mN_rdone. In GNT1, s_rdone and s_wdone in the same cycle -> both forwarded to m1 and a single transition to GAP.
- Reset mid-grant: assert rst_n=0 during GNT1, then release with an s_wdone pulse -> no m1_wdone, state IDLE, last=1.
